mux16_bus_arbiter: RTL and testbench
====================================

Name: mux16_bus_arbiter

Overview:
- Shares one 16-bit transfer path between two requesters, A and B, using round-robin arbitration with bounded bursts.
- Drives the select of a 16-bit 2:1 data mux and registers the selected word onto a single output bus with a valid strobe.
- Sits between two producer blocks (e.g. ALU result and memory read-back) and a shared downstream register/bus.

Parameters:
- WIDTH, 16, data width of each requester and the output bus
- MAX_BURST, 4, maximum consecutive transfers per grant tenure when the other side is requesting (must be >= 1)
- CNT_W, 2, burst counter width; must satisfy 2^CNT_W >= MAX_BURST

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_a  in  1  requester A wants to transfer; held high for the whole burst
- data_a  in  WIDTH  requester A word, sampled when gnt_a & req_a
- req_b  in  1  requester B wants to transfer
- data_b  in  WIDTH  requester B word, sampled when gnt_b & req_b
- gnt_a  out  1  A owns the path this cycle (registered)
- gnt_b  out  1  B owns the path this cycle (registered)
- sel  out  1  mux select: 0 = A, 1 = B; equals gnt_b
- out_data  out  WIDTH  registered transferred word
- out_valid  out  1  out_data holds a new word this cycle
- out_src  out  1  source of the current out_data: 0 = A, 1 = B

Behaviour:
- Reset: one clock, rst high, synchronous. Next state IDLE.
  - gnt_a = gnt_b = sel = 0, out_valid = 0, out_data = 0, out_src = 0.
  - burst_cnt = 0; last_served = B, so A wins the first tie.
  - Reset mid-burst drops the in-flight transfer; out_valid is 0 on the cycle after the reset edge.
- States: IDLE, OWN_A, OWN_B. gnt_a = (state==OWN_A), gnt_b = (state==OWN_B). Never both high.
- Transfer: occurs in a cycle where state==OWN_x and req_x==1.
  - Next edge: out_data <= data_x, out_src <= x, out_valid <= 1.
  - Otherwise out_valid <= 0; out_data and out_src hold their values.
  - Latency: one cycle from sampled data to out_valid.
- IDLE:
  - Both requesting: go to the side != last_served.
  - One requesting: go to that side.
  - Neither: stay. burst_cnt = 0.
  - Grant appears the cycle after the request is seen (1-cycle arbitration latency).
- OWN_A (OWN_B symmetric):
  - req_a==0: no transfer this cycle; next = OWN_B if req_b, else IDLE. last_served <= A; burst_cnt <= 0.
  - req_a==1 and burst_cnt==MAX_BURST-1 and req_b==1: transfer, then next = OWN_B; last_served <= A; burst_cnt <= 0.
  - req_a==1 and burst_cnt==MAX_BURST-1 and req_b==0: transfer, stay in OWN_A; burst_cnt <= 0 (new tenure, no idle gap).
  - Otherwise: transfer, stay; burst_cnt <= burst_cnt+1.
- Handover A->B is direct, with no IDLE bubble.
- The requester must keep req high until it sees its grant. Dropping req while granted releases the path at the next edge. No word is lost or duplicated.
- Simultaneous req edges in IDLE are resolved purely by last_served.
- No backpressure: the downstream must accept every out_valid word.

Decomposition:
- Shared defines/include file: state encodings (IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10) and the SEL_A=0 / SEL_B=1 constants.
- Data path reuses the existing bit16_2to1mux (S=sel, A=data_a, B=data_b) followed by a WIDTH-bit enabled register.
- No new sub-module. The FSM, burst counter and last_served flop live in this block.

Test Plan:
- Reset then idle: rst high 2 cycles, all req low -> gnt_a=gnt_b=0, out_valid=0, out_data=16'h0000 every cycle.
- Single requester: req_a=1 for 6 cycles, data_a=16'h0001..0006 -> gnt_a from cycle 1. out_valid high cycles 2-7 with 0001..0006, out_src=0. No gap at the burst-4 boundary.
- Tie: req_a=req_b=1 continuously -> A gets 4 words (out_src=0). gnt_b then rises directly, B gets 4, then A again. out_valid never drops after the first word.
- Early release: grant A, req_a drops after 2 words, req_b=1 -> gnt_b the next cycle. Exactly 2 A words then B words (data_b=16'hBEEF), no duplicates.
- Fairness after idle: B served last, then both req rise together in IDLE -> A granted first.
- Mid-burst reset: rst asserted during the third A word -> the cycle after the reset edge has out_valid=0, gnt_a=0, out_data=16'h0000. After release with both requesting, A is granted first.

Source files
------------

// File: rtl/mux16_bus_arbiter_pkg.sv
// rtl/mux16_bus_arbiter_pkg.sv - shared state encodings and mux select constants
package mux16_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/bit16_2to1mux.sv
// rtl/bit16_2to1mux.sv - 2:1 word mux, S=0 passes A, S=1 passes B
module bit16_2to1mux #(
  parameter int WIDTH = 16
) (
  input  logic             S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y
);

  // Pure combinational select
  assign Y = S ? B : A;

endmodule

// File: rtl/mux16_bus_arbiter.sv
// rtl/mux16_bus_arbiter.sv - round-robin two-requester arbiter with bounded bursts onto one registered bus
module mux16_bus_arbiter
  import mux16_bus_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_src
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nx;
  logic             last_served, last_served_nx;
  logic             xfer;
  logic             tenure_end;
  logic [WIDTH-1:0] mux_out;

  // Grants come straight from the state flops, so they are registered
  assign gnt_a = (state == OWN_A);
  assign gnt_b = (state == OWN_B);
  assign sel   = gnt_b ? SEL_B : SEL_A;

  // A word moves whenever the owner is still requesting
  assign xfer       = (gnt_a & req_a) | (gnt_b & req_b);
  assign tenure_end = (burst_cnt == CNT_W'(MAX_BURST - 1));

  bit16_2to1mux #(.WIDTH(WIDTH)) u_mux (
    .S (sel),
    .A (data_a),
    .B (data_b),
    .Y (mux_out)
  );

  // Arbitration state, burst counter and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= SEL_B;
    end else begin
      state       <= state_nx;
      burst_cnt   <= burst_cnt_nx;
      last_served <= last_served_nx;
    end
  end

  // Next-state: idle ties go to the side not served last; full bursts hand over only if the other side waits
  always_comb begin
    state_nx       = state;
    burst_cnt_nx   = burst_cnt;
    last_served_nx = last_served;
    case (state)
      IDLE: begin
        burst_cnt_nx = '0;
        if (req_a && req_b) state_nx = (last_served == SEL_A) ? OWN_B : OWN_A;
        else if (req_a)     state_nx = OWN_A;
        else if (req_b)     state_nx = OWN_B;
      end
      OWN_A: begin
        if (!req_a) begin
          state_nx       = req_b ? OWN_B : IDLE;
          last_served_nx = SEL_A;
          burst_cnt_nx   = '0;
        end else if (tenure_end) begin
          burst_cnt_nx = '0;
          if (req_b) begin
            state_nx       = OWN_B;
            last_served_nx = SEL_A;
          end
        end else begin
          burst_cnt_nx = burst_cnt + 1'b1;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_nx       = req_a ? OWN_A : IDLE;
          last_served_nx = SEL_B;
          burst_cnt_nx   = '0;
        end else if (tenure_end) begin
          burst_cnt_nx = '0;
          if (req_a) begin
            state_nx       = OWN_A;
            last_served_nx = SEL_B;
          end
        end else begin
          burst_cnt_nx = burst_cnt + 1'b1;
        end
      end
      default: begin
        state_nx     = IDLE;
        burst_cnt_nx = '0;
      end
    endcase
  end

  // Output register: captures the muxed word on a transfer, otherwise holds with valid low
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_src   <= SEL_A;
      out_valid <= 1'b0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_out;
        out_src  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mux16_bus_arbiter.sv
// tb/tb_mux16_bus_arbiter.sv - directed and randomized checks against a behavioural arbiter model
module tb_mux16_bus_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst, req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        gnt_a, gnt_b, sel, out_valid, out_src;
  logic [15:0] out_data;

  int errors = 0;
  int checks = 0;

  // Reference model: owner 0=none 1=A 2=B, words moved in this tenure, last side served
  int          m_owner, m_words, m_last;
  logic        m_valid, m_src;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  mux16_bus_arbiter #(.WIDTH(16), .MAX_BURST(MAXB), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_src(out_src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    if (rst) begin
      m_owner = 0; m_words = 0; m_last = 2;
      m_valid = 1'b0; m_data = 16'h0; m_src = 1'b0;
      return;
    end
    m_valid = 1'b0;
    if (m_owner == 0) begin
      m_words = 0;
      if (req_a && req_b) m_owner = (m_last == 1) ? 2 : 1;
      else if (req_a)     m_owner = 1;
      else if (req_b)     m_owner = 2;
    end else begin
      int   me, other;
      logic my_req, other_req;
      me        = m_owner;
      other     = 3 - me;
      my_req    = (me == 1) ? req_a : req_b;
      other_req = (me == 1) ? req_b : req_a;
      if (!my_req) begin
        m_last  = me;
        m_words = 0;
        m_owner = other_req ? other : 0;
      end else begin
        m_valid = 1'b1;
        m_data  = (me == 1) ? data_a : data_b;
        m_src   = (me == 2);
        m_words++;
        if (m_words == MAXB) begin
          m_words = 0;
          if (other_req) begin
            m_owner = other;
            m_last  = me;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_gnt_a"}, gnt_a, m_owner == 1);
    check({tag, "_gnt_b"}, gnt_b, m_owner == 2);
    check({tag, "_sel"}, sel, m_owner == 2);
    check({tag, "_valid"}, out_valid, m_valid);
    check({tag, "_data"}, out_data, m_data);
    check({tag, "_src"}, out_src, m_src);
  endtask

  task automatic step(input logic r, input logic ra, input logic rb,
                      input logic [15:0] da, input logic [15:0] db, input string tag);
    rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db;
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    // Reset then idle
    step(1, 0, 0, 16'h0, 16'h0, "reset");
    step(1, 0, 0, 16'h0, 16'h0, "reset");
    check("rst_data", out_data, 16'h0000);
    check("rst_valid", out_valid, 1'b0);
    step(0, 0, 0, 16'h0, 16'h0, "idle");
    step(0, 0, 0, 16'h0, 16'h0, "idle");

    // Single requester: words 1..6 with no gap across the burst boundary
    for (int j = 1; j <= 7; j++) begin
      step(0, 1, 0, (j >= 2) ? 16'(j - 1) : 16'h1, 16'h0, "single");
      check("single_gnt", gnt_a, 1'b1);
      if (j >= 2) begin
        check("single_valid", out_valid, 1'b1);
        check("single_word", out_data, 16'(j - 1));
      end
    end
    step(0, 0, 0, 16'h0, 16'h0, "release");

    // Tie after reset: A gets 4, B gets 4, alternating with no bubble
    step(1, 0, 0, 16'h0, 16'h0, "tie_rst");
    for (int j = 1; j <= 18; j++) begin
      step(0, 1, 1, 16'hA000 + 16'(j), 16'hB000 + 16'(j), "tie");
      if (j >= 2) begin
        check("tie_valid", out_valid, 1'b1);
        check("tie_src", out_src, ((j - 2) / 4) % 2);
      end
    end

    // Early release: two A words, then direct handover to B
    step(1, 0, 0, 16'h0, 16'h0, "er_rst");
    step(0, 1, 0, 16'h1111, 16'h0, "er");
    step(0, 1, 0, 16'h1111, 16'h0, "er");
    step(0, 1, 1, 16'h2222, 16'hBEEF, "er");
    step(0, 0, 1, 16'h0, 16'hBEEF, "er");
    check("er_gnt_b", gnt_b, 1'b1);
    check("er_no_dup", out_valid, 1'b0);
    step(0, 0, 1, 16'h0, 16'hBEEF, "er");
    check("er_beef", out_data, 16'hBEEF);
    check("er_src", out_src, 1'b1);

    // Fairness: B served last, both rise together in IDLE, A wins
    step(0, 0, 0, 16'h0, 16'h0, "fair");
    step(0, 0, 0, 16'h0, 16'h0, "fair");
    step(0, 1, 1, 16'h3333, 16'h4444, "fair");
    check("fair_gnt_a", gnt_a, 1'b1);

    // Mid-burst reset during the third A word
    step(0, 0, 0, 16'h0, 16'h0, "mid");
    step(0, 0, 0, 16'h0, 16'h0, "mid");
    step(0, 1, 0, 16'h0001, 16'h0, "mid");
    step(0, 1, 0, 16'h0001, 16'h0, "mid");
    step(0, 1, 0, 16'h0002, 16'h0, "mid");
    step(1, 1, 0, 16'h0003, 16'h0, "mid_rst");
    check("mid_valid", out_valid, 1'b0);
    check("mid_gnt", gnt_a, 1'b0);
    check("mid_data", out_data, 16'h0000);
    step(0, 1, 1, 16'h5555, 16'h6666, "mid");
    check("mid_first_a", gnt_a, 1'b1);

    // Randomized traffic: requests stay up until granted, drop only while granted
    begin
      logic ra, rb, r;
      ra = 1'b0; rb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        r = ($urandom_range(0, 99) == 0);
        if (!ra) ra = ($urandom_range(0, 2) == 0);
        else if (m_owner == 1 && $urandom_range(0, 5) == 0) ra = 1'b0;
        if (!rb) rb = ($urandom_range(0, 2) == 0);
        else if (m_owner == 2 && $urandom_range(0, 5) == 0) rb = 1'b0;
        step(r, ra, rb, 16'($urandom), 16'($urandom), "rand");
        check("rand_excl", gnt_a & gnt_b, 1'b0);
        if (r) begin ra = 1'b0; rb = 1'b0; end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
